// File: rtl/request_encoder.sv
// request_encoder: collects one-bit service requests on four lines and issues
// them one at a time as a 2-bit address with an enable, under a valid/ack
// handshake. Arbitration is round-robin (RR=1) or fixed lowest-index-first
// priority (RR=0).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req0..req3 request lines; a 1 on an edge is one request
//   ack        downstream accepts {addr1,addr0} when enable=1 at an edge
//   addr0      LSB of granted index (registered)
//   addr1      MSB of granted index (registered)
//   enable     address valid (registered)
//   pending    outstanding requests, bit i for req i (registered)
//   overrun    sticky lost-request flag, cleared only by reset (registered)
module request_encoder #(
    parameter int unsigned RR = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    input  logic       ack,
    output logic       addr0,
    output logic       addr1,
    output logic       enable,
    output logic [3:0] pending,
    output logic       overrun
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    state_t              state_q,   state_d;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [ADDR_W-1:0]   last_q,    last_d;
    logic                overrun_q, overrun_d;

    logic [N_REQ-1:0]    req_vec;
    logic [N_REQ-1:0]    clear_mask;
    logic [N_REQ-1:0]    cand;
    logic                accept;
    logic                load;
    logic [ADDR_W-1:0]   sel;

    // Round-robin pick: first set bit of c scanning last+1, last+2, ... mod 4.
    function automatic logic [ADDR_W-1:0] pick_rr(input logic [N_REQ-1:0]  c,
                                                  input logic [ADDR_W-1:0] last);
        logic [ADDR_W-1:0] idx;
        logic              found;
        pick_rr = last;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + ADDR_W'(k);
            if (!found && c[idx]) begin
                pick_rr = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Fixed priority pick: lowest set index of c.
    function automatic logic [ADDR_W-1:0] pick_fixed(input logic [N_REQ-1:0] c);
        pick_fixed = '0;
        for (int k = 3; k >= 0; k--) begin
            if (c[k]) begin
                pick_fixed = ADDR_W'(k);
            end
        end
    endfunction

    assign req_vec = {req3, req2, req1, req0};

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            last_q    <= ADDR_W'(3);
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: pending bookkeeping, overrun detection, output load and grant.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        last_d     = last_q;
        overrun_d  = overrun_q;
        sel        = '0;

        accept     = (state_q == ST_VALID) && ack;
        clear_mask = accept ? (N_REQ'(1) << addr_q) : '0;

        // Bits still owed after this edge's accept; new requests are excluded.
        cand       = pending_q & ~clear_mask;

        // A new request always wins over a same-edge clear.
        pending_d  = req_vec | cand;

        // Lost request: arrives while its bit is still owed after this edge.
        if ((req_vec & cand) != '0) begin
            overrun_d = 1'b1;
        end

        if (RR != 0) begin
            sel = pick_rr(cand, last_q);
        end else begin
            sel = pick_fixed(cand);
        end

        // Output register only moves when empty or when the current grant is taken.
        load = (state_q == ST_IDLE) || accept;
        if (load) begin
            if (cand == '0) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_VALID;
                addr_d  = sel;
            end
        end

        if (accept) begin
            last_d = addr_q;
        end
    end

    assign enable  = (state_q == ST_VALID);
    assign addr0   = addr_q[0];
    assign addr1   = addr_q[1];
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_request_encoder.sv
// Bench for request_encoder: drives an RR=1 and an RR=0 instance from the same
// inputs and compares both against a behavioural model every cycle, with
// directed scenarios followed by random traffic.
module tb_request_encoder;

    logic       clk;
    logic       reset_n;
    logic       req0, req1, req2, req3;
    logic       ack;

    logic       a0_r, a1_r, en_r, ovr_r;
    logic [3:0] pend_r;
    logic       a0_f, a1_f, en_f, ovr_f;
    logic [3:0] pend_f;

    int checks;
    int failures;

    // Model state, index 0 = fixed priority, 1 = round-robin.
    int mpend [2][4];
    int men   [2];
    int maddr [2];
    int mlast [2];
    int movr  [2];

    request_encoder #(.RR(1)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .req2(req2), .req3(req3),
        .ack(ack),
        .addr0(a0_r), .addr1(a1_r), .enable(en_r),
        .pending(pend_r), .overrun(ovr_r)
    );

    request_encoder #(.RR(0)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .req2(req2), .req3(req3),
        .ack(ack),
        .addr0(a0_f), .addr1(a1_f), .enable(en_f),
        .pending(pend_f), .overrun(ovr_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) mpend[m][i] = 0;
            men[m]   = 0;
            maddr[m] = 0;
            mlast[m] = 3;
            movr[m]  = 0;
        end
    endtask

    // One rising edge of the reference behaviour, written from the rules:
    // serve, update outstanding set, then choose the next grant.
    task automatic model_step(input logic [3:0] r, input logic a);
        int acc, s, sel, idx;
        int cand [4];
        for (int m = 0; m < 2; m++) begin
            acc = (men[m] != 0 && a) ? 1 : 0;
            s   = maddr[m];
            for (int i = 0; i < 4; i++)
                cand[i] = (mpend[m][i] != 0 && !(acc != 0 && s == i)) ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                if (r[i] && cand[i] != 0) movr[m] = 1;
                mpend[m][i] = r[i] ? 1 : cand[i];
            end
            if (men[m] == 0 || acc != 0) begin
                sel = -1;
                for (int k = 0; k < 4; k++) begin
                    idx = (m == 1) ? (mlast[m] + 1 + k) % 4 : k;
                    if (sel < 0 && cand[idx] != 0) sel = idx;
                end
                if (sel < 0) begin
                    men[m] = 0;
                end else begin
                    men[m]   = 1;
                    maddr[m] = sel;
                end
            end
            if (acc != 0) mlast[m] = s;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] p;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) p[i] = (mpend[m][i] != 0);
            if (m == 1) begin
                chk({tag, "_rr_en"},   8'(en_r),           8'(men[m]));
                chk({tag, "_rr_pend"}, 8'(pend_r),         8'(p));
                chk({tag, "_rr_ovr"},  8'(ovr_r),          8'(movr[m]));
                if (men[m] != 0) chk({tag, "_rr_addr"}, 8'({a1_r, a0_r}), 8'(maddr[m]));
            end else begin
                chk({tag, "_fp_en"},   8'(en_f),           8'(men[m]));
                chk({tag, "_fp_pend"}, 8'(pend_f),         8'(p));
                chk({tag, "_fp_ovr"},  8'(ovr_f),          8'(movr[m]));
                if (men[m] != 0) chk({tag, "_fp_addr"}, 8'({a1_f, a0_f}), 8'(maddr[m]));
            end
        end
    endtask

    // Drive inputs away from the edge, clock once, advance model, compare.
    task automatic step(input string tag, input logic [3:0] r, input logic a);
        {req3, req2, req1, req0} = r;
        ack = a;
        @(posedge clk);
        model_step(r, a);
        #1;
        compare_all(tag);
    endtask

    // Mid-cycle asynchronous reset, released on the following falling edge.
    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        chk({tag, "_en0"},   8'(en_r),           8'h00);
        chk({tag, "_addr0"}, 8'({a1_r, a0_r}),   8'h00);
        chk({tag, "_pend0"}, 8'(pend_r),         8'h00);
        chk({tag, "_ovr0"},  8'(ovr_r),          8'h00);
        {req3, req2, req1, req0} = 4'b0000;
        ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [3:0] rr_seq [6];
    logic [3:0] fp_seq [6];
    logic [3:0] rq;

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        {req3, req2, req1, req0} = 4'b0000;
        ack = 1'b0;
        model_reset();
        #12;
        compare_all("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Reset values: build enable=1, pending=0110, then reset mid-cycle.
        step("rv_a", 4'b0110, 1'b0);
        step("rv_b", 4'b0000, 1'b0);
        chk("rv_pre_en",   8'(en_r),   8'h01);
        chk("rv_pre_pend", 8'(pend_r), 8'h06);
        apply_reset("rv_rst");
        step("rv_c", 4'b0100, 1'b0);
        step("rv_d", 4'b0000, 1'b0);
        chk("rv_first_grant", 8'({en_r, a1_r, a0_r}), 8'b110);

        // Single request with stall.
        apply_reset("sg_rst");
        step("sg_req", 4'b0100, 1'b0);
        chk("sg_lat_en", 8'(en_r), 8'h00);
        step("sg_valid", 4'b0000, 1'b0);
        chk("sg_grant", 8'({en_r, a1_r, a0_r}), 8'b110);
        for (int i = 0; i < 5; i++) begin
            step("sg_stall", 4'b0000, 1'b0);
            chk("sg_stall_hold", 8'({en_r, a1_r, a0_r}), 8'b110);
        end
        step("sg_acc", 4'b0000, 1'b1);
        chk("sg_idle", 8'({en_r, pend_r}), 8'h00);

        // Burst drain from a fresh reset.
        apply_reset("bd_rst");
        step("bd_req", 4'b1111, 1'b1);
        for (int g = 0; g < 4; g++) begin
            step("bd_drain", 4'b0000, 1'b1);
            chk("bd_rr_addr", 8'({en_r, a1_r, a0_r}), 8'(4 + g));
            chk("bd_fp_addr", 8'({en_f, a1_f, a0_f}), 8'(4 + g));
        end
        step("bd_end", 4'b0000, 1'b1);
        chk("bd_rr_idle", 8'(en_r), 8'h00);
        chk("bd_fp_idle", 8'(en_f), 8'h00);

        // Round-robin fairness versus fixed priority with req0..2 held.
        rr_seq = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
        fp_seq = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
        apply_reset("rr_rst");
        step("rr_fill", 4'b0111, 1'b1);
        for (int g = 0; g < 6; g++) begin
            step("rr_hold", 4'b0111, 1'b1);
            chk("rr_grant", 8'({en_r, a1_r, a0_r}), 8'(4'd4 + rr_seq[g]));
            chk("fp_grant", 8'({en_f, a1_f, a0_f}), 8'(4'd4 + fp_seq[g]));
        end
        step("rr_stop", 4'b0000, 1'b0);

        // Overrun: second req1 while still pending.
        apply_reset("ov_rst");
        step("ov_a", 4'b0010, 1'b0);
        step("ov_b", 4'b0000, 1'b0);
        step("ov_c", 4'b0010, 1'b0);
        chk("ov_set", 8'(ovr_r), 8'h01);
        step("ov_d", 4'b0000, 1'b1);
        chk("ov_sticky", 8'(ovr_r), 8'h01);
        step("ov_e", 4'b0000, 1'b0);
        chk("ov_sticky2", 8'(ovr_f), 8'h01);

        // No overrun when the request lands on the edge that serves it.
        apply_reset("nv_rst");
        step("nv_a", 4'b0010, 1'b0);
        step("nv_b", 4'b0000, 1'b0);
        step("nv_c", 4'b0010, 1'b1);
        chk("nv_ovr", 8'(ovr_r), 8'h00);
        step("nv_d", 4'b0000, 1'b0);
        chk("nv_regrant", 8'({en_r, a1_r, a0_r}), 8'b101);
        chk("nv_ovr2", 8'(ovr_r), 8'h00);

        // Random traffic against the model.
        apply_reset("rn_rst");
        for (int n = 0; n < 600; n++) begin
            rq = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            step("rand", rq, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 8; n++) step("rand_drain", 4'b0000, 1'b1);
        chk("rand_idle_rr", 8'(en_r), 8'h00);
        chk("rand_idle_fp", 8'(en_f), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/request_encoder.md
# request_encoder

Sequential 4-to-2 request encoder: the inverse of the 2-to-4 decoder. It collects one-bit service requests on four lines and emits them one at a time as a 2-bit binary address with an enable, using a valid/acknowledge handshake. Its `addr0`, `addr1` and `enable` outputs are sized and ordered to drive the decoder's `addr0`, `addr1` and `enable` inputs directly. Arbitration is round-robin by default, or fixed priority.

## Interface

Parameters:
- `RR`, default 1. 1 selects round-robin arbitration; 0 selects fixed priority, lowest index first.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `req0`..`req3`  in  1 each  request lines, sampled every rising edge; a 1 for one cycle is one request.
- `ack`  in  1  downstream accepts the current address when `enable`=1 and `ack`=1 at a rising edge.
- `addr0`  out  1  LSB of the granted index.
- `addr1`  out  1  MSB of the granted index.
- `enable`  out  1  address valid.
- `pending`  out  4  outstanding requests; bit i corresponds to `req`i.
- `overrun`  out  1  sticky flag: a request was lost.

## Operation

- **Reset (async, `reset_n`=0):**
  - `pending`=0000, `enable`=0, `addr1:addr0`=00, `overrun`=0.
  - Internal last-grant pointer `last`=3.
  - All state holds while `reset_n`=0; operation resumes at the first rising edge after release.
- **Accept:** accept = `enable` & `ack` at a rising edge; the served index s = {`addr1`,`addr0`}.
- **Pending update, per bit i, each edge:**
  - Set if `req`i=1.
  - Else clear if accept and s=i.
  - Else hold.
  - If `req`i arrives on the same edge that serves i, the new request wins and the bit stays 1.
- **Overrun:** set when `req`i=1 while `pending`[i]=1, unless that same edge clears bit i by accept. The flag is cleared only by reset.
- **Output load condition:** the output register loads when `enable`=0 or accept. Otherwise `addr`/`enable` hold unchanged; this stall rule is mandatory.
- **Candidate set:** C = `pending` (value before this edge), with bit s removed if accept.
  - Requests arriving on this edge are not in C.
  - If C is empty: `enable`←0 and `addr` holds its old value.
  - Else: `enable`←1 and `addr`←the selected index.
- **Selection:**
  - RR=1: the first set bit of C scanning `last`+1, `last`+2, … modulo 4, with wrap-around (3 → 0).
  - RR=0: the lowest set index of C.
- **`last` update:** `last` ← s on every accept, for both RR settings; it is only used when RR=1.
- **`enable`=0 with nothing pending:** a valid idle state. The downstream decoder then drives all-zero outputs.

## Timing

- **Latency:** `req`i sampled at edge t gives `pending`[i]=1 after t. With the output idle, `enable`=1 and `addr`=i after edge t+1 (2 edges from request to valid).
- **Throughput:** with `ack` held at 1 and requests pending, one accept per cycle with no bubbles.
- **`ack` while `enable`=0:** ignored.
- **Idle:** `enable` drops the cycle after the last accept when C is empty.
- **Registered outputs:** all outputs are registered; there is no combinational path from any input to any output.

## Test plan

- **Reset values:** assert `reset_n`=0 mid-cycle with `enable`=1 and `pending`=0110 → immediately `enable`=0, `addr`=00, `pending`=0000, `overrun`=0. After release, `req2` → first grant `addr`=10, confirming `last`=3.
- **Single request and stall:** pulse `req2` at edge 0 with `ack`=0 → `enable`=1, `addr1:addr0`=10 after edge 1, stable for 5 stalled cycles. `ack`=1 → accept, then `enable`=0 and `pending`=0000.
- **Burst drain:** `req0`..`req3` all pulsed on one edge, `ack`=1 → addresses 00, 01, 10, 11 on consecutive cycles, then `enable`=0.
- **Round-robin fairness:** RR=1, `req0`, `req1`, `req2` held at 1, `ack`=1 → grant sequence 0, 1, 2, 0, 1, 2.
- **Fixed priority:** RR=0 with the same stimulus → grant sequence 0, 1, 0, 1, and index 2 is never granted.
- **Overrun:**
  - Pulse `req1` twice, 2 cycles apart, with `ack`=0 → `overrun`=1 and it stays 1 after the grant is accepted.
  - Pulse `req1` on the edge that accepts index 1 → `overrun` stays 0 and index 1 is granted again.
